// File: rtl/char_stream_buffer.sv
// Character FIFO between an upstream reader and a parser, with back-pressure and end-of-stream flag.
// Optional whitespace collapsing is enabled by defining CHAR_STREAM_BUFFER_WS_COLLAPSE_EN.
module char_stream_buffer #(
  parameter int unsigned CHAR_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [CHAR_W-1:0]        char,
  input  logic                     has_finished_connection,
  output logic                     pause_connection,
  output logic [CHAR_W-1:0]        out_char,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     stream_done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [CHAR_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              pause_q, pause_d;
  logic              done_q, done_d;
  logic              accept;
  logic              wr_en;
  logic              rd_en;
  logic [CHAR_W-1:0] wr_data;

  // Reader and buffer both see the registered pause, so an offered char is never lost.
  assign accept = !has_finished_connection && !pause_q;
  assign rd_en  = (count_q != '0) && out_ready;

`ifdef CHAR_STREAM_BUFFER_WS_COLLAPSE_EN
  typedef enum logic {TEXT, IN_WS} ws_state_t;

  ws_state_t ws_state_q, ws_state_d;
  logic      is_ws;

  assign is_ws = (char == CHAR_W'(8'h20)) || (char == CHAR_W'(8'h09)) ||
                 (char == CHAR_W'(8'h0A)) || (char == CHAR_W'(8'h0D));

  always_ff @(posedge clock) begin
    if (!resetn) ws_state_q <= TEXT;
    else         ws_state_q <= ws_state_d;
  end

  // A whitespace run writes a single space; later whitespace is consumed silently.
  always_comb begin
    ws_state_d = ws_state_q;
    wr_en      = 1'b0;
    wr_data    = char;
    if (accept) begin
      if (is_ws) begin
        ws_state_d = IN_WS;
        if (ws_state_q == TEXT) begin
          wr_en   = 1'b1;
          wr_data = CHAR_W'(8'h20);
        end
      end else begin
        ws_state_d = TEXT;
        wr_en      = 1'b1;
      end
    end
  end
`else
  always_comb begin
    wr_en   = accept;
    wr_data = char;
  end
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    pause_d  = (count_d == CW'(DEPTH));
    // The filter never holds a char back, so only occupancy gates completion.
    done_d   = has_finished_connection && (count_d == '0);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pause_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pause_q  <= pause_d;
      done_q   <= done_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign out_char         = mem_q[rd_ptr_q];
  assign out_valid        = (count_q != '0);
  assign count            = count_q;
  assign pause_connection = pause_q;
  assign stream_done      = done_q;

endmodule

// File: tb/tb_char_stream_buffer.sv
// Self-checking bench for char_stream_buffer: vector table plus model-driven scoreboard sequences.
module tb_char_stream_buffer;

  localparam int unsigned CHAR_W = 8;
  localparam int unsigned DEPTH  = 16;

  logic             clock;
  logic             resetn;
  logic [CHAR_W-1:0] char_in;
  logic             has_finished_connection;
  logic             pause_connection;
  logic [CHAR_W-1:0] out_char;
  logic             out_valid;
  logic             out_ready;
  logic             stream_done;
  logic [4:0]       count;

  char_stream_buffer #(.CHAR_W(CHAR_W), .DEPTH(DEPTH)) dut (
    .clock                   (clock),
    .resetn                  (resetn),
    .char                    (char_in),
    .has_finished_connection (has_finished_connection),
    .pause_connection        (pause_connection),
    .out_char                (out_char),
    .out_valid               (out_valid),
    .out_ready               (out_ready),
    .stream_done             (stream_done),
    .count                   (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [7:0] sb_q[$];
  int         m_count;
  logic       m_pause;
  logic       m_done;
  logic       m_ws;

  typedef struct {
    logic       hf;
    logic [7:0] ch;
    logic       rdy;
    int         exp_count;
  } vec_t;

  vec_t       tbl[4];
  logic [7:0] s037[6];

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    has_finished_connection = 1'b1;
    out_ready = 1'b0;
    char_in = '0;
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    sb_q.delete();
    m_count = 0;
    m_pause = 1'b0;
    m_done  = 1'b0;
    m_ws    = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_pause", 32'(pause_connection), 0);
    check("rst_done", 32'(stream_done), 0);
  endtask

  // One clock: drive inputs, predict, check head before the edge and state after it.
  task automatic step(input logic hf, input logic [7:0] c, input logic rdy, output logic acc);
    logic       pop;
    logic       wr;
    logic [7:0] wd;
    logic       is_ws;
    has_finished_connection = hf;
    char_in = c;
    out_ready = rdy;
    #1;
    check("out_valid", 32'(out_valid), 32'(m_count != 0));
    if (m_count != 0) check("head", 32'(out_char), 32'(sb_q[0]));
    pop = rdy && (m_count != 0);
    acc = !hf && !m_pause;
    wr  = 1'b0;
    wd  = c;
    is_ws = (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
    if (acc) begin
`ifdef CHAR_STREAM_BUFFER_WS_COLLAPSE_EN
      if (is_ws) begin
        if (!m_ws) begin
          wr = 1'b1;
          wd = 8'h20;
        end
        m_ws = 1'b1;
      end else begin
        wr = 1'b1;
        m_ws = 1'b0;
      end
`else
      wr = 1'b1;
`endif
    end
    if (pop) void'(sb_q.pop_front());
    if (wr) sb_q.push_back(wd);
    m_count = sb_q.size();
    m_pause = (m_count == DEPTH);
    m_done  = hf && (m_count == 0);
    @(posedge clock);
    @(negedge clock);
    check("count", 32'(count), 32'(m_count));
    check("pause", 32'(pause_connection), 32'(m_pause));
    check("stream_done", 32'(stream_done), 32'(m_done));
  endtask

  task automatic drain();
    logic a;
    for (int k = 0; k < 3 * DEPTH && m_count != 0; k++) step(1'b1, 8'h00, 1'b1, a);
    check("drain_empty", 32'(count), 0);
  endtask

  initial begin
    logic acc;
    int   idx;
    resetn = 1'b0;
    has_finished_connection = 1'b1;
    char_in = '0;
    out_ready = 1'b0;

    tbl[0] = '{hf: 1'b0, ch: 8'h61, rdy: 1'b1, exp_count: 1};
    tbl[1] = '{hf: 1'b0, ch: 8'h62, rdy: 1'b1, exp_count: 1};
    tbl[2] = '{hf: 1'b1, ch: 8'h00, rdy: 1'b1, exp_count: 0};
    tbl[3] = '{hf: 1'b1, ch: 8'h00, rdy: 1'b1, exp_count: 0};
    s037[0] = 8'h61; s037[1] = 8'h20; s037[2] = 8'h09;
    s037[3] = 8'h0A; s037[4] = 8'h20; s037[5] = 8'h62;

    // "ab" streamed straight through
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(tbl[i].hf, tbl[i].ch, tbl[i].rdy, acc);
      check("tbl_count", 32'(count), 32'(tbl[i].exp_count));
    end

    // 20 chars into a stalled parser, then drain
    do_reset();
    idx = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 8'h41 + 8'(idx), 1'b0, acc);
      if (acc) idx++;
    end
    check("full_idx", 32'(idx), 16);
    check("full_count", 32'(count), 16);
    check("full_pause", 32'(pause_connection), 1);
    for (int k = 0; k < 60 && idx < 20; k++) begin
      step(1'b0, 8'h41 + 8'(idx), 1'b1, acc);
      if (acc) idx++;
    end
    check("all_written", 32'(idx), 20);
    drain();

    // Sustained write+pop near full, then full with pop
    do_reset();
    for (int k = 0; k < 15; k++) step(1'b0, 8'h61 + 8'(k), 1'b0, acc);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 8'h30 + 8'(k), 1'b1, acc);
      check("wp_count", 32'(count), 15);
      check("wp_pause", 32'(pause_connection), 0);
    end
    step(1'b0, 8'h4B, 1'b0, acc);
    check("fill16", 32'(count), 16);
    step(1'b0, 8'h4C, 1'b1, acc);
    check("pop_from_full", 32'(count), 15);
    step(1'b0, 8'h4C, 1'b1, acc);
    drain();

    // Reset mid-transfer with 7 buffered
    do_reset();
    for (int k = 0; k < 7; k++) step(1'b0, 8'h70 + 8'(k), 1'b0, acc);
    check("seven", 32'(count), 7);
    do_reset();
    step(1'b0, 8'h5A, 1'b0, acc);
    check("post_rst_head", 32'(out_char), 32'h5A);
    drain();

    // stream_done after the last of 3 pops, then upstream reopens
    do_reset();
    step(1'b0, 8'h78, 1'b0, acc);
    step(1'b0, 8'h79, 1'b0, acc);
    step(1'b0, 8'h7A, 1'b0, acc);
    step(1'b1, 8'h00, 1'b1, acc);
    check("done_early1", 32'(stream_done), 0);
    step(1'b1, 8'h00, 1'b1, acc);
    check("done_early2", 32'(stream_done), 0);
    step(1'b1, 8'h00, 1'b1, acc);
    check("done_set", 32'(stream_done), 1);
    step(1'b1, 8'h00, 1'b1, acc);
    check("done_hold", 32'(stream_done), 1);
    step(1'b0, 8'h71, 1'b0, acc);
    check("done_clear", 32'(stream_done), 0);
    check("resume_write", 32'(count), 1);
    drain();

    // Whitespace run
    do_reset();
    idx = 0;
    for (int k = 0; k < 20 && idx < 6; k++) begin
      step(1'b0, s037[idx], 1'b0, acc);
      if (acc) idx++;
    end
`ifdef CHAR_STREAM_BUFFER_WS_COLLAPSE_EN
    check("ws_count", 32'(count), 3);
`else
    check("ws_count", 32'(count), 6);
`endif
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
